// File: rtl/axi_wr_rsp_fifo_if.sv
// AXI write-response (B) channel bundle.
// The master modport drives the response; the slave modport accepts it.
interface axi_wr_rsp_fifo_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned USER_WIDTH = 1
) ();

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic [USER_WIDTH-1:0] buser;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output bid,
    output bresp,
    output buser,
    output bvalid,
    input  bready
  );

  modport slave (
    input  bid,
    input  bresp,
    input  buser,
    input  bvalid,
    output bready
  );

endinterface

// File: rtl/axi_wr_rsp_fifo.sv
// First-word-fall-through buffer for the AXI B channel.
// Also monitors delivered responses for SLVERR/DECERR.
module axi_wr_rsp_fifo #(
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned USER_WIDTH    = 1,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  axi_wr_rsp_fifo_if.slave         s_b,
  axi_wr_rsp_fifo_if.master        m_b,
  input  logic                     err_clr,
  output logic                     err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ID_WIDTH-1:0]      err_last_id,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned EntW = ID_WIDTH + 2 + USER_WIDTH;

  logic [EntW-1:0]          mem_q [DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]          level_q, level_d;
  logic                     err_sticky_q, err_sticky_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [ID_WIDTH-1:0]      err_last_id_q, err_last_id_d;

  logic                     push, pop, err_pop;
  logic [EntW-1:0]          head;
  logic [ERR_CNT_WIDTH-1:0] cnt_base;

  // Handshake outputs come only from registered occupancy.
  assign s_b.bready = (level_q != LvlW'(DEPTH));
  assign m_b.bvalid = (level_q != '0);

  assign head = mem_q[rd_ptr_q];
  assign {m_b.bid, m_b.bresp, m_b.buser} = head;

  assign push    = s_b.bvalid & s_b.bready;
  assign pop     = m_b.bvalid & m_b.bready;
  assign err_pop = pop & m_b.bresp[1];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) level_d = level_q + LvlW'(1);
    else if (!push && pop) level_d = level_q - LvlW'(1);
  end

  // Clear takes effect first so an error popped in the same cycle is still counted.
  always_comb begin
    cnt_base      = err_clr ? '0 : err_cnt_q;
    err_cnt_d     = cnt_base;
    err_sticky_d  = err_clr ? 1'b0 : err_sticky_q;
    err_last_id_d = err_clr ? '0 : err_last_id_q;
    if (err_pop) begin
      err_sticky_d  = 1'b1;
      err_last_id_d = m_b.bid;
      if (cnt_base != '1) err_cnt_d = cnt_base + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      err_sticky_q  <= 1'b0;
      err_cnt_q     <= '0;
      err_last_id_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= {s_b.bid, s_b.bresp, s_b.buser};
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      err_sticky_q  <= err_sticky_d;
      err_cnt_q     <= err_cnt_d;
      err_last_id_q <= err_last_id_d;
    end
  end

  assign err_sticky  = err_sticky_q;
  assign err_cnt     = err_cnt_q;
  assign err_last_id = err_last_id_q;
  assign level       = level_q;

endmodule

// File: tb/tb_axi_wr_rsp_fifo.sv
// Randomised and directed bench for axi_wr_rsp_fifo against a queue-based model.
module tb_axi_wr_rsp_fifo;

  localparam int unsigned IdW   = 4;
  localparam int unsigned UserW = 1;
  localparam int unsigned Depth = 4;
  localparam int unsigned ErrW  = 2;
  localparam int          ErrMax = (1 << ErrW) - 1;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [1:0]       resp;
    logic [UserW-1:0] usr;
  } ent_t;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 err_clr = 1'b0;
  logic                 err_sticky;
  logic [ErrW-1:0]      err_cnt;
  logic [IdW-1:0]       err_last_id;
  logic [$clog2(Depth):0] level;

  axi_wr_rsp_fifo_if #(.ID_WIDTH(IdW), .USER_WIDTH(UserW)) s_b ();
  axi_wr_rsp_fifo_if #(.ID_WIDTH(IdW), .USER_WIDTH(UserW)) m_b ();

  axi_wr_rsp_fifo #(
    .ID_WIDTH     (IdW),
    .USER_WIDTH   (UserW),
    .DEPTH        (Depth),
    .ERR_CNT_WIDTH(ErrW)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_b        (s_b),
    .m_b        (m_b),
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .err_last_id(err_last_id),
    .level      (level)
  );

  always #5 aclk = ~aclk;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q[$];
  bit   m_sticky;
  int   m_cnt;
  int   m_last;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    check_eq("s_bready", 32'(s_b.bready), 32'(q.size() != Depth));
    check_eq("m_bvalid", 32'(m_b.bvalid), 32'(q.size() != 0));
    check_eq("level", 32'(level), 32'(q.size()));
    check_eq("err_sticky", 32'(err_sticky), 32'(m_sticky));
    check_eq("err_cnt", 32'(err_cnt), 32'(m_cnt));
    check_eq("err_last_id", 32'(err_last_id), 32'(m_last));
    if (q.size() != 0) begin
      check_eq("m_bid", 32'(m_b.bid), 32'(q[0].id));
      check_eq("m_bresp", 32'(m_b.bresp), 32'(q[0].resp));
      check_eq("m_buser", 32'(m_b.buser), 32'(q[0].usr));
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sticky = 1'b0;
    m_cnt    = 0;
    m_last   = 0;
  endtask

  // One clock: drive, check at negedge, advance model at posedge.
  task automatic step(input logic sv, input logic [IdW-1:0] id, input logic [1:0] resp,
                      input logic usr, input logic mr, input logic clr);
    ent_t h;
    bit   do_push, do_pop;
    s_b.bvalid = sv;
    s_b.bid    = id;
    s_b.bresp  = resp;
    s_b.buser  = usr;
    m_b.bready = mr;
    err_clr    = clr;
    @(negedge aclk);
    check_model();
    do_push = sv && (q.size() < Depth);
    do_pop  = mr && (q.size() != 0);
    @(posedge aclk);
    if (clr) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
      m_last   = 0;
    end
    if (do_pop) begin
      h = q.pop_front();
      if (h.resp[1]) begin
        m_sticky = 1'b1;
        if (m_cnt < ErrMax) m_cnt++;
        m_last = int'(h.id);
      end
    end
    if (do_push) begin
      h.id   = id;
      h.resp = resp;
      h.usr  = usr;
      q.push_back(h);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  logic [1:0] err_seq [4];

  initial begin
    model_reset();
    s_b.bvalid = 1'b0;
    s_b.bid    = '0;
    s_b.bresp  = '0;
    s_b.buser  = '0;
    m_b.bready = 1'b0;
    #12;
    check_eq("rst_s_bready", 32'(s_b.bready), 32'd1);
    check_eq("rst_m_bvalid", 32'(m_b.bvalid), 32'd0);
    check_eq("rst_m_bid", 32'(m_b.bid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Single push then pop.
    step(1'b1, 4'd3, 2'b00, 1'b0, 1'b0, 1'b0);
    check_eq("first_valid", 32'(m_b.bvalid), 32'd1);
    check_eq("first_bid", 32'(m_b.bid), 32'd3);
    step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    check_eq("first_drain_level", 32'(level), 32'd0);

    // Fill with master stalled, then a held-off fifth beat.
    for (int i = 1; i <= 4; i++) step(1'b1, IdW'(i), 2'b00, 1'b1, 1'b0, 1'b0);
    check_eq("full_level", 32'(level), 32'd4);
    check_eq("full_s_bready", 32'(s_b.bready), 32'd0);
    step(1'b1, 4'd15, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    check_eq("after_pop_s_bready", 32'(s_b.bready), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(1);

    // Steady push/pop at level 2 exercises pointer wrap.
    step(1'b1, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd2, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 5; i <= 14; i++) begin
      step(1'b1, IdW'(i), 2'b00, 1'b0, 1'b1, 1'b0);
      check_eq("stream_level", 32'(level), 32'd2);
    end
    step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0);

    // Error monitor.
    err_seq[0] = 2'b00;
    err_seq[1] = 2'b10;
    err_seq[2] = 2'b01;
    err_seq[3] = 2'b11;
    for (int i = 0; i < 4; i++) step(1'b1, IdW'(7 + i), err_seq[i], 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(2);
    check_eq("err_sticky_set", 32'(err_sticky), 32'd1);
    check_eq("err_cnt_two", 32'(err_cnt), 32'd2);
    check_eq("err_last_ten", 32'(err_last_id), 32'd10);
    step(1'b1, 4'd6, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b1);
    check_eq("clr_pop_cnt", 32'(err_cnt), 32'd1);
    check_eq("clr_pop_id", 32'(err_last_id), 32'd6);
    check_eq("clr_pop_sticky", 32'(err_sticky), 32'd1);

    // Saturation of the 2-bit counter.
    step(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
    check_eq("clr_only_cnt", 32'(err_cnt), 32'd0);
    check_eq("clr_only_sticky", 32'(err_sticky), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, IdW'(i), 2'b10, 1'b0, 1'b1, 1'b0);
    idle(1);
    check_eq("sat_cnt", 32'(err_cnt), 32'd3);
    check_eq("sat_sticky", 32'(err_sticky), 32'd1);

    // Randomised traffic with backpressure.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), IdW'($urandom), 2'($urandom), UserW'($urandom),
           1'($urandom_range(0, 2) != 0 ? 1 : 0), 1'($urandom_range(0, 40) == 0 ? 1 : 0));
    end

    // Asynchronous reset with three entries queued.
    while (q.size() != 0) step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, IdW'(9 + i), 2'b11, 1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_level", 32'(level), 32'd3);
    s_b.bvalid = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("arst_m_bvalid", 32'(m_b.bvalid), 32'd0);
    check_eq("arst_level", 32'(level), 32'd0);
    check_eq("arst_s_bready", 32'(s_b.bready), 32'd1);
    check_eq("arst_m_bid", 32'(m_b.bid), 32'd0);
    check_eq("arst_err_cnt", 32'(err_cnt), 32'd0);
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd12, 2'b01, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_rsp_fifo.md
# axi_wr_rsp_fifo

Parametrised AXI write-response (B) channel buffer between a write slave's B output and the upstream master's B input. It decouples the two sides with a DEPTH-entry first-word-fall-through FIFO. It carries configurable ID/USER widths with a full 2-bit BRESP, and monitors delivered responses for SLVERR/DECERR. The monitor reports a sticky error flag, a saturating error counter and the ID of the most recent error, all readable by the CNN control logic.

## Interface
- ID_WIDTH, 4, width of bid.
- USER_WIDTH, 1, width of buser (≥1).
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ERR_CNT_WIDTH, 8, width of saturating error counter.

- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  reset, asynchronous, active-low.
- s_bid  input  ID_WIDTH  response ID from slave side.
- s_bresp  input  2  response code from slave side.
- s_buser  input  USER_WIDTH  user sideband from slave side.
- s_bvalid  input  1  slave-side valid.
- s_bready  output  1  ready to slave side.
- m_bid  output  ID_WIDTH  head-entry ID.
- m_bresp  output  2  head-entry response.
- m_buser  output  USER_WIDTH  head-entry user.
- m_bvalid  output  1  head entry valid.
- m_bready  input  1  master-side ready.
- err_clr  input  1  synchronous clear of error status.
- err_sticky  output  1  set once any delivered response had bresp[1]=1.
- err_cnt  output  ERR_CNT_WIDTH  delivered error responses, saturating.
- err_last_id  output  ID_WIDTH  bid of most recent delivered error.
- level  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- The circular buffer uses write/read pointers of $clog2(DEPTH) bits with natural wrap, plus an occupancy counter `level` (0..DEPTH).
- Push = s_bvalid & s_bready; pop = m_bvalid & m_bready.
- s_bready = (level != DEPTH). It depends only on registered state, with no combinational path from m_bready.
- m_bvalid = (level != 0). m_bid/m_bresp/m_buser are driven from the entry at the read pointer. When m_bvalid=0 their value is don't-care but must not be X after reset; the storage array is reset to 0.
- Simultaneous push and pop: `level` is unchanged and both pointers advance. This is legal at any level except full (no push when full) and empty (no pop when empty).
- Payload must stay stable while m_bvalid=1 and m_bready=0.
- The error monitor evaluates on pop only. An error is bresp[1]=1 (2'b10 SLVERR, 2'b11 DECERR). OKAY and EXOKAY are not errors.
- On an error pop:
  - err_sticky goes to 1.
  - err_cnt increments, saturating at 2^ERR_CNT_WIDTH−1.
  - err_last_id takes m_bid.
- err_clr clears err_sticky, err_cnt and err_last_id to 0.
- err_clr in the same cycle as an error pop: the clear is applied first, then the event is counted. The result is err_sticky=1, err_cnt=1, err_last_id=that bid.
- Reset asserted mid-operation: all contents are discarded, pointers and level go to 0, and all outputs return to reset values immediately (asynchronously).

## Timing
- Reset values:
  - s_bready=1, m_bvalid=0.
  - m_bid/m_bresp/m_buser=0.
  - err_sticky=0, err_cnt=0, err_last_id=0, level=0.
- Latency: a push at edge N makes m_bvalid=1 after edge N when previously empty, i.e. 1 cycle. There is no combinational bypass.
- Full: s_bready falls the cycle after the DEPTH-th push. A pop from full reasserts s_bready after that edge.
- Sustained throughput is 1 response/cycle with both sides always ready.
- Error status updates on the same edge as the pop that caused it.
- The order of responses is preserved exactly; there is no reordering by ID.

## Test plan
- Reset then idle:
  - s_bready=1, m_bvalid=0, level=0, err_cnt=0.
  - Push bid=3, bresp=00 → m_bvalid=1 the next cycle with m_bid=3; m_bready=1 pops it and level returns to 0.
- Fill with m_bready=0, DEPTH=4, bids 1,2,3,4:
  - level=4 and s_bready=0, with a 5th beat held off.
  - Drain gives bids 1,2,3,4 in order; s_bready=1 after the first pop.
- Simultaneous push/pop at level=2 for 10 cycles, bids 5..14:
  - level stays 2.
  - Output order is the prior 2 entries then 5..12, confirming pointer wrap.
- Error monitor:
  - Deliver bresp 00,10,01,11 with bids 7,8,9,10 → err_sticky=1, err_cnt=2, err_last_id=10.
  - err_clr with an error pop of bid=6 in the same cycle → err_cnt=1, err_last_id=6.
- Saturation with ERR_CNT_WIDTH=2: deliver 5 SLVERR responses → err_cnt stops at 3 and err_sticky=1.
- Backpressure stability and mid-run reset:
  - Randomise m_bready; payload is held while m_bvalid & !m_bready.
  - Assert aresetn=0 with level=3 → next observation shows m_bvalid=0, level=0, s_bready=1, and no stale entry is emitted afterwards.
